// File: rtl/program_sequencer.sv
// Program-memory address sequencer: increment / jump / conditional jump / call / return.
// The return-address stack is built only when PROGRAM_SEQUENCER_CALL_STACK_EN is defined.
module program_sequencer #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       async_reset_n,
  input  logic       hold,
  input  logic       jump,
  input  logic       conditional_jump,
  input  logic       call,
  input  logic       ret,
  input  logic [3:0] jump_addr,
  input  logic       r_eq_0,
  output logic [7:0] pm_addr,
  output logic [7:0] pc,
  output logic       stack_empty,
  output logic       stack_full,
  output logic       stack_err
);

  logic [7:0] pm_addr_q, pm_addr_d, pc_q;
  logic [7:0] incr_addr, target_addr;
  logic       cond_taken;

  assign incr_addr   = pm_addr_q + 8'd1;
  assign target_addr = {jump_addr, 4'h0};
  assign cond_taken  = conditional_jump && !r_eq_0;

`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(STACK_DEPTH);

  logic [7:0]       stack_q [STACK_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_ptr;
  logic             err_q, err_d, push;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             unused_top_msb;

  // ptr_q counts held entries, so the top entry lives at ptr_q-1.
  assign top_ptr        = ptr_q - PTR_W'(1);
  assign wr_idx         = ptr_q[IDX_W-1:0];
  assign rd_idx         = top_ptr[IDX_W-1:0];
  assign unused_top_msb = top_ptr[PTR_W-1];

  always_comb begin
    pm_addr_d = incr_addr;
    ptr_d     = ptr_q;
    err_d     = err_q;
    push      = 1'b0;
    if (ret) begin
      if (ptr_q != '0) begin
        pm_addr_d = stack_q[rd_idx];
        ptr_d     = top_ptr;
      end else begin
        err_d = 1'b1;
      end
    end else if (call) begin
      pm_addr_d = target_addr;
      if (ptr_q != FULL_PTR) begin
        push  = 1'b1;
        ptr_d = ptr_q + PTR_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (jump || cond_taken) begin
      pm_addr_d = target_addr;
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else if (!hold) begin
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  // Entries carry no reset; their contents only matter once pushed.
  for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!hold && push && (wr_idx == IDX_W'(gi))) begin
        stack_q[gi] <= incr_addr;
      end
    end
  end

  assign stack_empty = (ptr_q == '0);
  assign stack_full  = (ptr_q == FULL_PTR);
  assign stack_err   = err_q;
`else
  localparam int unused_depth_p = STACK_DEPTH;
  logic unused_ret;
  assign unused_ret = ret;

  // Without a stack, call degenerates to jump and ret to a plain increment.
  always_comb begin
    pm_addr_d = incr_addr;
    if (!ret && (call || jump || cond_taken)) begin
      pm_addr_d = target_addr;
    end
  end

  assign stack_empty = 1'b1;
  assign stack_full  = 1'b0;
  assign stack_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      pm_addr_q <= 8'h00;
      pc_q      <= 8'h00;
    end else if (!hold) begin
      pm_addr_q <= pm_addr_d;
      pc_q      <= pm_addr_q;
    end
  end

  assign pm_addr = pm_addr_q;
  assign pc      = pc_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed plan with literal expectations plus random run
// checked every cycle against a queue-based reference model.
module tb_program_sequencer;
  localparam int DEPTH = 4;
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       async_reset_n;
  logic       hold, jump, conditional_jump, call, ret, r_eq_0;
  logic [3:0] jump_addr;
  logic [7:0] pm_addr, pc;
  logic       stack_empty, stack_full, stack_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  program_sequencer #(.STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .async_reset_n(async_reset_n), .hold(hold), .jump(jump),
    .conditional_jump(conditional_jump), .call(call), .ret(ret),
    .jump_addr(jump_addr), .r_eq_0(r_eq_0), .pm_addr(pm_addr), .pc(pc),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Reference model: addresses as integers, return stack as a queue.
  int m_pm, m_pc;
  bit m_err;
  int m_stack[$];

  always @(posedge clk or negedge async_reset_n) begin
    int nxt, tgt;
    if (!async_reset_n) begin
      m_pm = 0; m_pc = 0; m_err = 0; m_stack.delete();
    end else if (!hold) begin
      nxt = (m_pm + 1) % 256;
      tgt = int'(jump_addr) * 16;
      if (ret) begin
        if (STACK_EN) begin
          if (m_stack.size() > 0) nxt = m_stack.pop_back();
          else m_err = 1;
        end
      end else if (call) begin
        if (STACK_EN) begin
          if (m_stack.size() < DEPTH) m_stack.push_back((m_pm + 1) % 256);
          else m_err = 1;
        end
        nxt = tgt;
      end else if (jump || (conditional_jump && !r_eq_0)) begin
        nxt = tgt;
      end
      m_pc = m_pm;
      m_pm = nxt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_pm_addr", 32'(pm_addr), 32'(m_pm));
      chk("model_pc", 32'(pc), 32'(m_pc));
      chk("model_empty", 32'(stack_empty), 32'(STACK_EN ? (m_stack.size() == 0) : 1));
      chk("model_full", 32'(stack_full), 32'(STACK_EN ? (m_stack.size() == DEPTH) : 0));
      chk("model_err", 32'(stack_err), 32'(STACK_EN ? m_err : 1'b0));
    end
  end

  // Apply one cycle of request inputs; returns after the following negedge.
  task automatic cyc(input logic j, input logic cj, input logic c, input logic r,
                     input logic h, input logic [3:0] a, input logic z);
    jump = j; conditional_jump = cj; call = c; ret = r; hold = h; jump_addr = a; r_eq_0 = z;
    @(negedge clk);
    $display("cyc j=%0b cj=%0b call=%0b ret=%0b hold=%0b a=%0h z=%0b -> pm=%02h pc=%02h e=%0b f=%0b err=%0b",
             j, cj, c, r, h, a, z, pm_addr, pc, stack_empty, stack_full, stack_err);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 4'h0, 1'b1);
  endtask

  logic [7:0] exp_ret [6];
  logic [7:0] exp_call [5];

  initial begin
    async_reset_n = 1'b0;
    hold = 0; jump = 0; conditional_jump = 0; call = 0; ret = 0; jump_addr = 0; r_eq_0 = 1;
    repeat (2) @(negedge clk);
    async_reset_n = 1'b1;
    chk("reset_pm", 32'(pm_addr), 32'h00);
    chk("reset_pc", 32'(pc), 32'h00);
    chk("reset_empty", 32'(stack_empty), 32'h1);
    chk("reset_full", 32'(stack_full), 32'h0);
    chk("reset_err", 32'(stack_err), 32'h0);
    chk_en = 1'b1;

    for (int i = 1; i <= 20; i++) begin
      idle();
      chk("freerun_pm", 32'(pm_addr), 32'(i));
      chk("freerun_pc", 32'(pc), 32'(i - 1));
    end

    cyc(1, 0, 0, 0, 0, 4'hF, 1'b1);
    chk("jump_F0", 32'(pm_addr), 32'hF0);
    repeat (14) idle();
    chk("at_FE", 32'(pm_addr), 32'hFE);
    idle(); chk("wrap_FF", 32'(pm_addr), 32'hFF);
    idle(); chk("wrap_00", 32'(pm_addr), 32'h00);
    idle(); chk("wrap_01", 32'(pm_addr), 32'h01);

    repeat (4) idle();
    chk("at_05", 32'(pm_addr), 32'h05);
    cyc(1, 0, 0, 0, 0, 4'hA, 1'b1);
    chk("jump_A0", 32'(pm_addr), 32'hA0);
    cyc(0, 1, 0, 0, 0, 4'h3, 1'b1);
    chk("cj_not_taken", 32'(pm_addr), 32'hA1);
    cyc(0, 1, 0, 0, 0, 4'h3, 1'b0);
    chk("cj_taken", 32'(pm_addr), 32'h30);

    cyc(1, 0, 0, 0, 0, 4'h1, 1'b1);
    idle(); idle();
    chk("at_12", 32'(pm_addr), 32'h12);
    cyc(0, 0, 1, 0, 0, 4'h4, 1'b1);
    chk("call_40", 32'(pm_addr), 32'h40);
    chk("call_nonempty", 32'(stack_empty), 32'(!STACK_EN));
    idle(); chk("call_41", 32'(pm_addr), 32'h41);
    idle(); chk("call_42", 32'(pm_addr), 32'h42);
    cyc(0, 0, 0, 1, 0, 4'h0, 1'b1);
    chk("ret_13", 32'(pm_addr), STACK_EN ? 32'h13 : 32'h43);
    chk("ret_empty", 32'(stack_empty), 32'h1);

    // Five nested calls from the current address, then returns with a hold pulse.
    if (STACK_EN) begin
      exp_call = '{8'h50, 8'h60, 8'h70, 8'h80, 8'h90};
      exp_ret  = '{8'h71, 8'h61, 8'h61, 8'h51, 8'h14, 8'h15};
    end else begin
      exp_call = '{8'h50, 8'h60, 8'h70, 8'h80, 8'h90};
      exp_ret  = '{8'h91, 8'h92, 8'h92, 8'h93, 8'h94, 8'h95};
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 0, 4'(5 + i), 1'b1);
      chk("nest_call_pm", 32'(pm_addr), 32'(exp_call[i]));
      chk("nest_full", 32'(stack_full), 32'(STACK_EN && i >= 3));
      chk("nest_err", 32'(stack_err), 32'(STACK_EN && i == 4));
    end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] pc_before;
      pc_before = pc;
      cyc(0, 0, 0, 1, (i == 2), 4'h0, 1'b1);
      chk("nest_ret_pm", 32'(pm_addr), 32'(exp_ret[i]));
      if (i == 2) chk("hold_pc", 32'(pc), 32'(pc_before));
    end
    chk("nest_end_empty", 32'(stack_empty), 32'h1);
    chk("nest_end_err", 32'(stack_err), 32'(STACK_EN));

    cyc(0, 0, 1, 0, 0, 4'h2, 1'b1);
    cyc(0, 0, 1, 0, 0, 4'h3, 1'b1);
    #3 async_reset_n = 1'b0;
    #1;
    chk("areset_pm", 32'(pm_addr), 32'h00);
    chk("areset_pc", 32'(pc), 32'h00);
    chk("areset_empty", 32'(stack_empty), 32'h1);
    chk("areset_full", 32'(stack_full), 32'h0);
    chk("areset_err", 32'(stack_err), 32'h0);
    @(negedge clk);
    async_reset_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      cyc(sel == 4, sel == 5 || sel == 6, sel == 0 || sel == 1, sel == 2 || sel == 3,
          ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_sequencer.md
# program_sequencer

Generates the 8-bit program-memory address for the 4-bit nibble processor and sits directly upstream of the instruction decoder and `computational_unit`. Each cycle it selects the next address: sequential increment, unconditional jump, conditional jump on the computational unit's `r_eq_0` flag, or subroutine call/return through a small hardware return-address stack. It also tracks the address of the instruction currently in execution for debug.

## Interface
- `STACK_DEPTH`, 4, number of return-address entries; power of two, 2..8.
- `clk` input 1: rising-edge clock shared with `computational_unit`.
- `async_reset_n` input 1: asynchronous, active-low reset.
- `hold` input 1: freeze all state this cycle.
- `jump` input 1: unconditional jump, from decoder.
- `conditional_jump` input 1: jump if `r_eq_0 == 0`, from decoder.
- `call` input 1: push return address, then jump.
- `ret` input 1: pop return address.
- `jump_addr` input 4: target nibble (decoder's `nibble_ir`).
- `r_eq_0` input 1: zero flag from `computational_unit`.
- `pm_addr` output 8: registered program-memory address.
- `pc` output 8: `pm_addr` delayed one cycle, the address of the instruction now in execution.
- `stack_empty` output 1: no entries held.
- `stack_full` output 1: `STACK_DEPTH` entries held.
- `stack_err` output 1: sticky overflow/underflow flag.

## Operation
- Jump target is `{jump_addr, 4'h0}`, i.e. 16-word aligned.
- Next-address priority, evaluated when `hold == 0`:
  1. `ret`
  2. `call`
  3. `jump`
  4. `conditional_jump && !r_eq_0`
  5. `pm_addr + 1`
- The decoder drives at most one of these requests per cycle. Priority applies regardless.
- `ret`:
  - Stack non-empty: next = top entry; pop.
  - Stack empty: next = `pm_addr + 1`; set `stack_err`.
- `call`:
  - Stack not full: push `pm_addr + 1` (mod 256); next = target.
  - Stack full: no push; next = target; set `stack_err`.
- Conditional jump not taken: next = `pm_addr + 1`.
- Increment wraps: 8'hFF -> 8'h00.
- Stack is LIFO with a pointer 0..`STACK_DEPTH`:
  - `stack_empty = (ptr == 0)`.
  - `stack_full = (ptr == STACK_DEPTH)`.
- `stack_err` stays set until reset.
- `hold == 1`:
  - `pm_addr`, `pc`, the stack and `stack_err` all keep their values.
  - All requests that cycle are ignored.

## Timing
- Reset (async assert, deasserted synchronously upstream):
  - `pm_addr = 8'h00`
  - `pc = 8'h00`
  - stack pointer = 0, so `stack_empty = 1` and `stack_full = 0`
  - `stack_err = 0`
  - Stack entries are don't-care.
- Reset asserted mid-call/ret: all state clears immediately and pending requests are lost.
- `pm_addr` updates on the rising `clk` edge following the request cycle.
  - Request inputs and `r_eq_0` are sampled combinationally at that edge.
  - Latency from request to new `pm_addr` is 1 cycle.
- `pc` = `pm_addr` of the previous cycle. On the first cycle after reset both are 0.
- Push/pop and the flag updates take effect on the same edge as `pm_addr`.
- `r_eq_0` is the registered flag from the computational unit. It reflects the last ALU result written by an instruction that has already completed.

## Configuration
- `PROGRAM_SEQUENCER_CALL_STACK_EN`:
  - Defined: call/ret stack behaves as specified above.
  - Undefined:
    - No stack storage is built.
    - `call` behaves as `jump`.
    - `ret` behaves as increment.
    - `stack_empty = 1`, `stack_full = 0`, `stack_err = 0` constantly.

## Test plan
- Reset then 20 free-run cycles -> `pm_addr` 0,1,...,20; `pc` lags by one.
- Preload `pm_addr = 8'hFE`, run 3 cycles -> `pm_addr` FF, 00, 01.
- At `pm_addr = 8'h05`, `jump` with `jump_addr = 4'hA` -> `pm_addr = 8'hA0`.
- Conditional jump with `jump_addr = 4'h3`:
  - `r_eq_0 = 1` -> `pm_addr + 1`.
  - `r_eq_0 = 0` -> 8'h30.
- Call at 8'h12 with `jump_addr = 4'h4`, run 2 cycles, then `ret` -> sequence 8'h40, 41, 42, 13; `stack_empty` returns to 1.
- Stack boundaries (`STACK_DEPTH = 4`):
  - 5 nested calls -> 5th still jumps, `stack_full = 1`, `stack_err = 1`.
  - Then 5 `ret`s -> 4 correct returns, 5th increments.
  - `hold` pulse mid-sequence -> no state change.
  - Async reset mid-sequence -> all outputs 0, `stack_empty = 1`.
